// File: rtl/d_bus_router.sv
// rtl/d_bus_router.sv - core data-bus router: RAM data port plus N_SLV peripheral windows
//
// Purpose
//   Routes one core load/store port either to the RAM data port (addr MSB = 0) or to one
//   of N_SLV peripheral windows (addr MSB = 1). A single-outstanding FSM sequences every
//   access and returns a one-cycle rd_ready / wr_ready pulse. Unmapped windows return an
//   error response (ERR_DATA, writes dropped) and record a sticky error.
//
// Optional feature macro
//   BUS_TIMEOUT_EN : a slave that does not answer within TIMEOUT_CYC cycles of IO_WAIT is
//                    abandoned and the access completes with an error response.
//
// Ports
//   clk, rstb                         clock, asynchronous active-low reset
//   addr, rd_req, wr_req, be, wr_data core request (held until the matching ready)
//   rd_ready, wr_ready, rd_data       core response (one-cycle pulses, rd_data holds)
//   ram_addr, ram_en, ram_we,
//   ram_wr_data, ram_rd_data          RAM data port, 1-cycle read latency
//   slv_addr, slv_rd_req, slv_wr_req,
//   slv_be, slv_wr_data               peripheral request side (reqs one-hot, registered)
//   slv_rd_data, slv_rd_ready,
//   slv_wr_ready                      peripheral response side
//   err_flag, err_addr, err_clr       sticky error status and its clear
module d_bus_router #(
    parameter int               XLEN         = 32,
    parameter int               ADDR_LEN     = 16,
    parameter int               RAM_ADDR_LEN = ADDR_LEN - 3,
    parameter int               N_SLV        = 4,
    parameter int               SLV_LSB      = 8,
    parameter logic [XLEN-1:0]  ERR_DATA     = XLEN'(32'hDEADBEEF),
    parameter int               TIMEOUT_CYC  = 255
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic [ADDR_LEN-1:0]     addr,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [XLEN/8-1:0]       be,
    input  logic [XLEN-1:0]         wr_data,
    output logic                    rd_ready,
    output logic                    wr_ready,
    output logic [XLEN-1:0]         rd_data,
    output logic [RAM_ADDR_LEN-1:0] ram_addr,
    output logic                    ram_en,
    output logic [XLEN/8-1:0]       ram_we,
    output logic [XLEN-1:0]         ram_wr_data,
    input  logic [XLEN-1:0]         ram_rd_data,
    output logic [SLV_LSB-1:0]      slv_addr,
    output logic [N_SLV-1:0]        slv_rd_req,
    output logic [N_SLV-1:0]        slv_wr_req,
    output logic [XLEN/8-1:0]       slv_be,
    output logic [XLEN-1:0]         slv_wr_data,
    input  logic [N_SLV*XLEN-1:0]   slv_rd_data,
    input  logic [N_SLV-1:0]        slv_rd_ready,
    input  logic [N_SLV-1:0]        slv_wr_ready,
    output logic                    err_flag,
    output logic [ADDR_LEN-1:0]     err_addr,
    input  logic                    err_clr
);

    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    // Every address bit between the window field and the RAM/IO select bit takes part in
    // the decode, so windows beyond N_SLV (including aliases) are unmapped.
    localparam int IDX_W = ADDR_LEN - 1 - SLV_LSB;
    localparam int BE_W  = XLEN / 8;

    if (N_SLV < 1 || N_SLV > 16) begin : g_bad_n_slv
        $error("d_bus_router: N_SLV must be 1..16");
    end
    if (SLV_LSB + SEL_W > ADDR_LEN - 1) begin : g_bad_window
        $error("d_bus_router: window select field overlaps the RAM/IO select bit");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("d_bus_router: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAM_RSP = 3'd1,
        S_IO_WAIT = 3'd2,
        S_IO_RSP  = 3'd3,
        S_ERR_RSP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [N_SLV-1:0]    slv_rd_req_q, slv_rd_req_d;
    logic [N_SLV-1:0]    slv_wr_req_q, slv_wr_req_d;
    logic [BE_W-1:0]     slv_be_q, slv_be_d;
    logic [XLEN-1:0]     slv_wr_data_q, slv_wr_data_d;
    logic [XLEN-1:0]     io_data_q, io_data_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic                err_flag_q, err_flag_d;
    logic [ADDR_LEN-1:0] err_addr_q, err_addr_d;

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`endif

    // Request decode
    logic                any_req;
    logic                to_ram;
    logic [IDX_W-1:0]    win_idx;
    logic                win_mapped;
    logic [SEL_W-1:0]    sel_idx;
    logic [N_SLV-1:0]    sel_oh;

    assign any_req    = rd_req | wr_req;
    assign to_ram     = ~addr[ADDR_LEN-1];
    assign win_idx    = addr[ADDR_LEN-2:SLV_LSB];
    assign win_mapped = (32'(win_idx) < $unsigned(N_SLV));
    assign sel_idx    = win_idx[SEL_W-1:0];

    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < N_SLV; k++) begin
            sel_oh[k] = (sel_idx == SEL_W'(k));
        end
    end

    // Response side of the slave latched in idx_q
    logic                sel_rd_rdy;
    logic                sel_wr_rdy;
    logic [XLEN-1:0]     sel_rd_data;

    always_comb begin
        sel_rd_rdy  = 1'b0;
        sel_wr_rdy  = 1'b0;
        sel_rd_data = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_rd_rdy  = slv_rd_ready[k];
                sel_wr_rdy  = slv_wr_ready[k];
                sel_rd_data = slv_rd_data[k*XLEN +: XLEN];
            end
        end
    end

    logic set_err;

    always_comb begin
        state_d       = state_q;
        is_wr_d       = is_wr_q;
        idx_d         = idx_q;
        slv_rd_req_d  = slv_rd_req_q;
        slv_wr_req_d  = slv_wr_req_q;
        slv_be_d      = slv_be_q;
        slv_wr_data_d = slv_wr_data_q;
        io_data_d     = io_data_q;
        rd_data_d     = rd_data_q;
        err_flag_d    = err_clr ? 1'b0 : err_flag_q;
        err_addr_d    = err_clr ? '0 : err_addr_q;
        set_err       = 1'b0;
        ram_en        = 1'b0;
        ram_we        = '0;
        rd_ready      = 1'b0;
        wr_ready      = 1'b0;
`ifdef BUS_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    // A simultaneous rd_req is dropped: the write is the transaction.
                    is_wr_d = wr_req;
                    if (to_ram) begin
                        ram_en  = 1'b1;
                        ram_we  = wr_req ? be : '0;
                        state_d = S_RAM_RSP;
                    end else if (win_mapped) begin
                        idx_d         = sel_idx;
                        slv_be_d      = be;
                        slv_wr_data_d = wr_data;
                        if (wr_req) begin
                            slv_wr_req_d = sel_oh;
                        end else begin
                            slv_rd_req_d = sel_oh;
                        end
`ifdef BUS_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                        state_d = S_IO_WAIT;
                    end else begin
                        set_err = 1'b1;
                        state_d = S_ERR_RSP;
                    end
                end
            end

            S_RAM_RSP: begin
                rd_ready = ~is_wr_q;
                wr_ready = is_wr_q;
                if (!is_wr_q) begin
                    rd_data_d = ram_rd_data;
                end
                state_d = S_IDLE;
            end

            S_IO_WAIT: begin
                // Only the matching handshake of the latched slave ends the wait.
                if (is_wr_q ? sel_wr_rdy : sel_rd_rdy) begin
                    slv_rd_req_d = '0;
                    slv_wr_req_d = '0;
                    io_data_d    = sel_rd_data;
                    state_d      = S_IO_RSP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    slv_rd_req_d = '0;
                    slv_wr_req_d = '0;
                    set_err      = 1'b1;
                    state_d      = S_ERR_RSP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end

            S_IO_RSP: begin
                rd_ready = ~is_wr_q;
                wr_ready = is_wr_q;
                if (!is_wr_q) begin
                    rd_data_d = io_data_q;
                end
                state_d = S_IDLE;
            end

            S_ERR_RSP: begin
                rd_ready = ~is_wr_q;
                wr_ready = is_wr_q;
                if (!is_wr_q) begin
                    rd_data_d = ERR_DATA;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The error is recorded as it is detected, so the flag is already visible during
        // the error pulse. A new error beats err_clr raised in the same cycle.
        if (set_err) begin
            err_flag_d = 1'b1;
            if (!err_flag_q || err_clr) begin
                err_addr_d = addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q       <= S_IDLE;
            is_wr_q       <= 1'b0;
            idx_q         <= '0;
            slv_rd_req_q  <= '0;
            slv_wr_req_q  <= '0;
            slv_be_q      <= '0;
            slv_wr_data_q <= '0;
            io_data_q     <= '0;
            rd_data_q     <= '0;
            err_flag_q    <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            is_wr_q       <= is_wr_d;
            idx_q         <= idx_d;
            slv_rd_req_q  <= slv_rd_req_d;
            slv_wr_req_q  <= slv_wr_req_d;
            slv_be_q      <= slv_be_d;
            slv_wr_data_q <= slv_wr_data_d;
            io_data_q     <= io_data_d;
            rd_data_q     <= rd_data_d;
            err_flag_q    <= err_flag_d;
            err_addr_q    <= err_addr_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // rd_data shows the response value during the pulse and holds it afterwards.
    assign rd_data     = rd_data_d;
    assign ram_addr    = addr[RAM_ADDR_LEN+1:2];
    assign ram_wr_data = wr_data;
    assign slv_addr    = addr[SLV_LSB-1:0];
    assign slv_rd_req  = slv_rd_req_q;
    assign slv_wr_req  = slv_wr_req_q;
    assign slv_be      = slv_be_q;
    assign slv_wr_data = slv_wr_data_q;
    assign err_flag    = err_flag_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_d_bus_router.sv
// tb/tb_d_bus_router.sv - scoreboard testbench for d_bus_router
module tb_d_bus_router;

    localparam int XLEN = 32;
    localparam int AL   = 16;
    localparam int RAL  = AL - 3;
    localparam int NS   = 4;

    logic            clk = 1'b0;
    logic            rstb;
    logic [AL-1:0]   addr;
    logic            rd_req, wr_req;
    logic [3:0]      be;
    logic [31:0]     wr_data;
    logic            rd_ready, wr_ready;
    logic [31:0]     rd_data;
    logic [RAL-1:0]  ram_addr;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [31:0]     ram_wr_data;
    logic [31:0]     ram_rd_data;
    logic [7:0]      slv_addr;
    logic [NS-1:0]   slv_rd_req, slv_wr_req;
    logic [3:0]      slv_be;
    logic [31:0]     slv_wr_data;
    logic [NS*32-1:0] slv_rd_data;
    logic [NS-1:0]   slv_rd_ready, slv_wr_ready;
    logic            err_flag;
    logic [AL-1:0]   err_addr;
    logic            err_clr;

    d_bus_router #(.XLEN(XLEN), .ADDR_LEN(AL), .N_SLV(NS), .SLV_LSB(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rstb(rstb), .addr(addr), .rd_req(rd_req), .wr_req(wr_req), .be(be),
        .wr_data(wr_data), .rd_ready(rd_ready), .wr_ready(wr_ready), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data), .slv_addr(slv_addr), .slv_rd_req(slv_rd_req),
        .slv_wr_req(slv_wr_req), .slv_be(slv_be), .slv_wr_data(slv_wr_data),
        .slv_rd_data(slv_rd_data), .slv_rd_ready(slv_rd_ready), .slv_wr_ready(slv_wr_ready),
        .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // RAM model: read-first, 1-cycle latency, byte writes
    logic [31:0] mem [0:(1<<RAL)-1];
    initial begin
        for (int i = 0; i < (1 << RAL); i++) mem[i] = '0;
        ram_rd_data = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rd_data <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
    end

    // Slave models: answer dly cycles after their req rises unless hung
    int          slv_dly [NS];
    logic [31:0] slv_val [NS];
    int          scnt    [NS];
    logic [NS-1:0] slv_hang, spur_rd, spur_wr;
    initial begin
        for (int k = 0; k < NS; k++) begin
            scnt[k] = 0;
            slv_dly[k] = 0;
            slv_val[k] = 32'h1111_1111 * (k + 1);
        end
    end
    always @(posedge clk) begin
        for (int k = 0; k < NS; k++)
            scnt[k] <= (slv_rd_req[k] | slv_wr_req[k]) ? scnt[k] + 1 : 0;
    end
    always_comb begin
        slv_rd_ready = spur_rd;
        slv_wr_ready = spur_wr;
        slv_rd_data  = '0;
        for (int k = 0; k < NS; k++) begin
            if (!slv_hang[k] && scnt[k] == slv_dly[k]) begin
                if (slv_rd_req[k]) slv_rd_ready[k] = 1'b1;
                if (slv_wr_req[k]) slv_wr_ready[k] = 1'b1;
            end
            slv_rd_data[k*32 +: 32] = slv_val[k];
        end
    end

    // Scoreboard: {is_read, read data}
    logic [32:0] exp_q [$];

    always @(negedge clk) begin
        if (rstb && (rd_ready || wr_ready)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", {30'd0, rd_ready, wr_ready}, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_rd_ready", {31'd0, rd_ready}, {31'd0, e[32]});
                chk("rsp_wr_ready", {31'd0, wr_ready}, {31'd0, ~e[32]});
                if (e[32]) chk("rsp_rd_data", rd_data, e[31:0]);
            end
        end
    end

    // One core transaction; starts just after a posedge with the FSM idle.
    task automatic txn(input string nm, input logic wr, input logic rd, input logic [15:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic clr,
                       input int exp_lat, input logic exp_ram_en, input logic [3:0] exp_we,
                       input logic [7:0] exp_sreq, input logic [31:0] exp_data);
        int  lat;
        bit  got;
        exp_q.push_back({~wr, exp_data});
        addr = a; be = b; wr_data = d; wr_req = wr; rd_req = rd; err_clr = clr;
        @(negedge clk);
        chk({nm, "_ram_en"}, {31'd0, ram_en}, {31'd0, exp_ram_en});
        chk({nm, "_ram_we"}, {28'd0, ram_we}, {28'd0, exp_we});
        lat = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            err_clr = 1'b0;
            @(negedge clk);
            if (lat == 1) begin
                chk({nm, "_slv_req"}, {24'd0, slv_wr_req, slv_rd_req}, {24'd0, exp_sreq});
                if (exp_sreq != 8'd0) chk({nm, "_slv_addr"}, {24'd0, slv_addr}, {24'd0, a[7:0]});
                if (exp_sreq[7:4] != 4'd0) begin
                    chk({nm, "_slv_be"}, {28'd0, slv_be}, {28'd0, b});
                    chk({nm, "_slv_wdata"}, slv_wr_data, d);
                end
            end
            if (rd_ready || wr_ready) got = 1;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        rstb = 1'b0; addr = '0; rd_req = 0; wr_req = 0; be = '0; wr_data = '0; err_clr = 0;
        slv_hang = '0; spur_rd = '0; spur_wr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_ready", {31'd0, rd_ready}, 32'd0);
        chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("reset_slv_req", {24'd0, slv_wr_req, slv_rd_req}, 32'd0);
        chk("reset_err_flag", {31'd0, err_flag}, 32'd0);
        chk("reset_err_addr", {16'd0, err_addr}, 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // RAM accesses
        txn("ram_wr",   1, 0, 16'h0010, 4'hF, 32'h1234_5678, 0, 1, 1, 4'hF, 8'h00, 32'h0);
        txn("ram_rd",   0, 1, 16'h0010, 4'hF, 32'h0,         0, 1, 1, 4'h0, 8'h00, 32'h1234_5678);
        txn("ram_wr14", 1, 0, 16'h0014, 4'hF, 32'h1122_3344, 0, 1, 1, 4'hF, 8'h00, 32'h0);
        txn("ram_wrbe", 1, 0, 16'h0014, 4'h3, 32'hAABB_CCDD, 0, 1, 1, 4'h3, 8'h00, 32'h0);
        txn("ram_rdbe", 0, 1, 16'h0014, 4'hF, 32'h0,         0, 1, 1, 4'h0, 8'h00, 32'h1122_CCDD);
        txn("both_req", 1, 1, 16'h0020, 4'hC, 32'hCAFE_F00D, 0, 1, 1, 4'hC, 8'h00, 32'h0);
        txn("both_rd",  0, 1, 16'h0020, 4'hF, 32'h0,         0, 1, 1, 4'h0, 8'h00, 32'hCAFE_0000);

        // Peripheral accesses
        slv_dly[2] = 3; slv_val[2] = 32'hA5A5_A5A5;
        txn("slv2_rd",  0, 1, 16'h8200, 4'hF, 32'h0,         0, 5, 0, 4'h0, 8'h04, 32'hA5A5_A5A5);
        slv_dly[0] = 0;
        txn("slv0_wr",  1, 0, 16'h8004, 4'h6, 32'h0BAD_F00D, 0, 2, 0, 4'h0, 8'h10, 32'h0);
        chk("rd_data_hold", rd_data, 32'hA5A5_A5A5);
        slv_dly[1] = 2;
        spur_rd = 4'b1000;
        spur_wr = 4'b0010;
        txn("slv1_spur", 0, 1, 16'h8133, 4'hF, 32'h0,        0, 4, 0, 4'h0, 8'h02, 32'h2222_2222);
        spur_rd = '0;
        spur_wr = '0;

        // Unmapped windows and the sticky error
        txn("err_rd",   0, 1, 16'h8400, 4'hF, 32'h0,         0, 1, 0, 4'h0, 8'h00, 32'hDEAD_BEEF);
        chk("err_flag_1", {31'd0, err_flag}, 32'd1);
        chk("err_addr_1", {16'd0, err_addr}, 32'h8400);
        txn("err_wr",   1, 0, 16'h9000, 4'hF, 32'h5555_5555, 0, 1, 0, 4'h0, 8'h00, 32'h0);
        chk("err_addr_keep", {16'd0, err_addr}, 32'h8400);
        chk("rd_data_after_errwr", rd_data, 32'hDEAD_BEEF);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr_flag", {31'd0, err_flag}, 32'd0);
        chk("err_clr_addr", {16'd0, err_addr}, 32'd0);
        txn("err_rd2",  0, 1, 16'h8400, 4'hF, 32'h0,         0, 1, 0, 4'h0, 8'h00, 32'hDEAD_BEEF);
        txn("err_clrwin", 0, 1, 16'h8500, 4'hF, 32'h0,       1, 1, 0, 4'h0, 8'h00, 32'hDEAD_BEEF);
        chk("err_win_flag", {31'd0, err_flag}, 32'd1);
        chk("err_win_addr", {16'd0, err_addr}, 32'h8500);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;

`ifdef BUS_TIMEOUT_EN
        slv_hang[1] = 1'b1;
        txn("timeout",  1, 0, 16'h8100, 4'hF, 32'h7777_7777, 0, 17, 0, 4'h0, 8'h20, 32'h0);
        chk("timeout_req_drop", {28'd0, slv_wr_req}, 32'd0);
        chk("timeout_err_flag", {31'd0, err_flag}, 32'd1);
        chk("timeout_err_addr", {16'd0, err_addr}, 32'h8100);
        slv_hang[1] = 1'b0;
`endif

        // Asynchronous reset in the middle of a slave wait
        slv_hang[3] = 1'b1;
        addr = 16'h8300; be = 4'hF; rd_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_slv_req", {28'd0, slv_rd_req}, 32'h8);
        rstb = 1'b0;
        #1;
        chk("arst_slv_req", {24'd0, slv_wr_req, slv_rd_req}, 32'd0);
        chk("arst_ready", {30'd0, rd_ready, wr_ready}, 32'd0);
        chk("arst_err_flag", {31'd0, err_flag}, 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        rd_req = 1'b0;
        slv_hang[3] = 1'b0;
        @(posedge clk);
        #1;
        rstb = 1'b1;
        @(posedge clk);
        #1;
        txn("post_rst_rd", 0, 1, 16'h0010, 4'hF, 32'h0,      0, 1, 1, 4'h0, 8'h00, 32'h1234_5678);

        repeat (3) @(posedge clk);
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
